// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: widths, op codes, FSM states.
// The divider datapath is only built when MDU_DIV_EN is defined.
package mdu_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned ITER  = 32;
   localparam int unsigned CNT_W = $clog2(ITER);

   typedef enum logic [1:0] {
      OpMult  = 2'b00,
      OpMultu = 2'b01,
      OpDiv   = 2'b10,
      OpDivu  = 2'b11
   } mduOp_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StMul  = 2'b01,
      StDiv  = 2'b10,
      StDone = 2'b11
   } mduState_e;

   // Two's-complement negate when neg is set; also used to take magnitudes.
   function automatic logic [XLEN-1:0] applySign(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shifted partial remainder minus divisor, keep or restore.
module mdu_divstep
   import mdu_pkg::*;
(
   input  logic [XLEN:0]   remIn,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] remOut,
   output logic            qBit
);

   logic [XLEN+1:0] diff;

   always_comb begin
      diff   = {1'b0, remIn} - {2'b00, divisor};
      qBit   = ~diff[XLEN+1];
      // Result is always below the divisor, so it fits in XLEN bits.
      remOut = qBit ? diff[XLEN-1:0] : remIn[XLEN-1:0];
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit for the EX stage (32-cycle shift-add / restoring).
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU complete at once with HI/LO held.
module ex_muldiv #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_MDU,
   input  logic            rstn_MDU,
   input  logic            start_MDU,
   input  logic [1:0]      op_MDU,
   input  logic [XLEN-1:0] opA_MDU,
   input  logic [XLEN-1:0] opB_MDU,
   input  logic            flush_MDU,
   output logic [XLEN-1:0] hi_MDU,
   output logic [XLEN-1:0] lo_MDU,
   output logic            busy_MDU,
   output logic            done_MDU,
   output logic            divz_MDU
);
   import mdu_pkg::*;

   mduState_e          stateQ, stateD;
   logic [CNT_W-1:0]   cntQ, cntD;
   logic [2*XLEN-1:0]  prodQ, prodD, mulNext;
   logic [XLEN:0]      mulSum;
   logic [XLEN-1:0]    mcandQ, mcandD, hiQ, hiD, loQ, loD, magA, magB;
   logic               negProdQ, negProdD, divzQ, divzD;
   logic               aNeg, bNeg, accept, lastIter;

`ifdef MDU_DIV_EN
   logic               negRemQ, negRemD, divByZero, qBit;
   logic [XLEN-1:0]    remNext;
   logic [2*XLEN-1:0]  divNext;

   // prodQ holds {remainder, dividend/quotient}; its top XLEN+1 bits are the shifted remainder.
   mdu_divstep u_divstep (
      .remIn   (prodQ[2*XLEN-1:XLEN-1]),
      .divisor (mcandQ),
      .remOut  (remNext),
      .qBit    (qBit)
   );
`endif

   assign accept   = start_MDU & ~flush_MDU & (stateQ == StIdle);
   assign lastIter = (cntQ == CNT_W'(ITER - 1));

   always_ff @(posedge clk_MDU or negedge rstn_MDU) begin
      if (!rstn_MDU) stateQ <= StIdle;
      else           stateQ <= stateD;
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle: if (accept) stateD = op_MDU[1] ? StDiv : StMul;
         StMul: begin
            if (flush_MDU)     stateD = StIdle;
            else if (lastIter) stateD = StDone;
         end
         StDiv: begin
            if (flush_MDU)                    stateD = StIdle;
`ifdef MDU_DIV_EN
            else if (divByZero || lastIter)   stateD = StDone;
`else
            else                              stateD = StDone;
`endif
         end
         StDone: stateD = StIdle;
      endcase
   end

   always_comb begin
      busy_MDU = (stateQ != StIdle);
      done_MDU = (stateQ == StDone);
      divz_MDU = (stateQ == StDone) & divzQ;
      hi_MDU   = hiQ;
      lo_MDU   = loQ;
   end

   always_comb begin
      prodD    = prodQ;
      mcandD   = mcandQ;
      cntD     = cntQ;
      hiD      = hiQ;
      loD      = loQ;
      negProdD = negProdQ;
      divzD    = divzQ;
      aNeg     = ~op_MDU[0] & opA_MDU[XLEN-1];
      bNeg     = ~op_MDU[0] & opB_MDU[XLEN-1];
      magA     = applySign(opA_MDU, aNeg);
      magB     = applySign(opB_MDU, bNeg);
      mulSum   = {1'b0, prodQ[2*XLEN-1:XLEN]} + (prodQ[0] ? {1'b0, mcandQ} : '0);
      mulNext  = {mulSum, prodQ[XLEN-1:1]};
`ifdef MDU_DIV_EN
      negRemD   = negRemQ;
      divNext   = {remNext, prodQ[XLEN-2:0], qBit};
      divByZero = (cntQ == '0) && (mcandQ == '0);
`endif
      unique case (stateQ)
         StIdle: begin
            if (accept) begin
               cntD     = '0;
               divzD    = 1'b0;
               negProdD = aNeg ^ bNeg;
               if (op_MDU[1]) begin
                  prodD  = {{XLEN{1'b0}}, magA};
                  mcandD = magB;
`ifdef MDU_DIV_EN
                  negRemD = aNeg;
`endif
               end else begin
                  prodD  = {{XLEN{1'b0}}, magB};
                  mcandD = magA;
               end
            end
         end
         StMul: begin
            if (!flush_MDU) begin
               prodD = mulNext;
               cntD  = cntQ + 1'b1;
               if (lastIter) {hiD, loD} = negProdQ ? (~mulNext + 1'b1) : mulNext;
            end
         end
         StDiv: begin
`ifdef MDU_DIV_EN
            if (!flush_MDU) begin
               if (divByZero) begin
                  // Dividend magnitude still sits in the low half; restore its sign for HI.
                  hiD   = applySign(prodQ[XLEN-1:0], negRemQ);
                  loD   = '1;
                  divzD = 1'b1;
               end else begin
                  prodD = divNext;
                  cntD  = cntQ + 1'b1;
                  if (lastIter) begin
                     loD = applySign(divNext[XLEN-1:0], negProdQ);
                     hiD = applySign(divNext[2*XLEN-1:XLEN], negRemQ);
                  end
               end
            end
`endif
         end
         StDone: begin
         end
      endcase
   end

   always_ff @(posedge clk_MDU or negedge rstn_MDU) begin
      if (!rstn_MDU) begin
         prodQ    <= '0;
         mcandQ   <= '0;
         cntQ     <= '0;
         hiQ      <= '0;
         loQ      <= '0;
         negProdQ <= 1'b0;
         divzQ    <= 1'b0;
`ifdef MDU_DIV_EN
         negRemQ  <= 1'b0;
`endif
      end else begin
         prodQ    <= prodD;
         mcandQ   <= mcandD;
         cntQ     <= cntD;
         hiQ      <= hiD;
         loQ      <= loD;
         negProdQ <= negProdD;
         divzQ    <= divzD;
`ifdef MDU_DIV_EN
         negRemQ  <= negRemD;
`endif
      end
   end

endmodule
